// File: rtl/spi_byte_engine_pkg.sv
// Shared types and defaults for the SPI mode-0 byte engine.
package spi_byte_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_GAP  = 2'd3
   } spi_state_e;

   localparam int   DEF_DATA_W     = 8;
   localparam int   DEF_CLK_DIV    = 1;
   localparam int   DEF_GAP_CYCLES = 1;
   localparam logic SPI_CPOL       = 1'b0;

   // Width able to hold 0..max_val, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      if (max_val < 1) begin
         return 1;
      end else begin
         return $clog2(max_val + 1);
      end
   endfunction

endpackage

// File: rtl/spi_byte_engine_phase_timer.sv
// Phase/gap counter: counts enabled edges up to last_i, pulses tc_o there and restarts at 0.
module spi_phase_timer #(
   parameter int CNT_W = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] last_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             tc_s;

   // Next count and terminal pulse.
   always_comb begin
      cnt_d = cnt_q;
      tc_s  = en_i && (cnt_q == last_i);
      if (clr_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (tc_s) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = tc_s;

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 full-duplex word shifter, MSB first, with a BUSY-extending inter-word gap.
module spi_byte_engine
   import spi_byte_engine_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              sndRec,
   input  logic [DATA_W-1:0] DIN,
   input  logic              MISO,
   output logic              SCLK,
   output logic              MOSI,
   output logic              BUSY,
   output logic [DATA_W-1:0] DOUT
);

   localparam int DIV_LAST = CLK_DIV - 1;
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam int CNT_W    = cnt_width((DIV_LAST > GAP_LAST) ? DIV_LAST : GAP_LAST);
   localparam int BIT_W    = cnt_width(DATA_W - 1);

   localparam logic [CNT_W-1:0] DIV_TC = CNT_W'(DIV_LAST);
   localparam logic [CNT_W-1:0] GAP_TC = CNT_W'(GAP_LAST);
   localparam logic [BIT_W-1:0] BIT_TC = BIT_W'(DATA_W - 1);

   spi_state_e        state_q,  state_d;
   logic [DATA_W-1:0] txsr_q,   txsr_d;
   logic [DATA_W-1:0] rxsr_q,   rxsr_d;
   logic [DATA_W-1:0] dout_q,   dout_d;
   logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
   logic              sclk_q,   sclk_d;
   logic              mosi_q,   mosi_d;
   logic              busy_q,   busy_d;

   logic              tmr_clr_s;
   logic              tmr_en_s;
   logic [CNT_W-1:0]  tmr_last_s;
   logic              tmr_tc_s;

   // One timer serves both SCLK half-periods and the trailing gap.
   spi_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk_i  (CLK),
      .rst_ni (RST),
      .clr_i  (tmr_clr_s),
      .en_i   (tmr_en_s),
      .last_i (tmr_last_s),
      .tc_o   (tmr_tc_s)
   );

   // Next-state and datapath control.
   always_comb begin
      state_d    = state_q;
      txsr_d     = txsr_q;
      rxsr_d     = rxsr_q;
      dout_d     = dout_q;
      bitcnt_d   = bitcnt_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      busy_d     = busy_q;
      tmr_clr_s  = 1'b0;
      tmr_en_s   = 1'b0;
      tmr_last_s = DIV_TC;

      case (state_q)
         ST_IDLE: begin
            tmr_clr_s = 1'b1;
            sclk_d    = SPI_CPOL;
            if (sndRec) begin
               txsr_d   = DIN;
               mosi_d   = DIN[DATA_W-1];
               busy_d   = 1'b1;
               bitcnt_d = {BIT_W{1'b0}};
               state_d  = ST_LOW;
            end else begin
               busy_d   = 1'b0;
            end
         end
         ST_LOW: begin
            tmr_en_s = 1'b1;
            if (tmr_tc_s) begin
               sclk_d  = 1'b1;
               rxsr_d  = {rxsr_q[DATA_W-2:0], MISO};
               state_d = ST_HIGH;
            end else begin
               state_d = ST_LOW;
            end
         end
         ST_HIGH: begin
            tmr_en_s = 1'b1;
            if (tmr_tc_s) begin
               sclk_d = 1'b0;
               if (bitcnt_q == BIT_TC) begin
                  dout_d = rxsr_q;
                  if (GAP_CYCLES > 0) begin
                     state_d = ST_GAP;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = ST_IDLE;
                  end
               end else begin
                  // MOSI only moves on the falling SCLK edge.
                  txsr_d   = {txsr_q[DATA_W-2:0], 1'b0};
                  mosi_d   = txsr_q[DATA_W-2];
                  bitcnt_d = bitcnt_q + BIT_W'(1);
                  state_d  = ST_LOW;
               end
            end else begin
               state_d = ST_HIGH;
            end
         end
         ST_GAP: begin
            tmr_en_s   = 1'b1;
            tmr_last_s = GAP_TC;
            if (tmr_tc_s) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_GAP;
            end
         end
         default: begin
            sclk_d  = SPI_CPOL;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any frame without touching DOUT beyond clearing it.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= ST_IDLE;
         txsr_q   <= {DATA_W{1'b0}};
         rxsr_q   <= {DATA_W{1'b0}};
         dout_q   <= {DATA_W{1'b0}};
         bitcnt_q <= {BIT_W{1'b0}};
         sclk_q   <= SPI_CPOL;
         mosi_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         txsr_q   <= txsr_d;
         rxsr_q   <= rxsr_d;
         dout_q   <= dout_d;
         bitcnt_q <= bitcnt_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
         busy_q   <= busy_d;
      end
   end

   assign SCLK = sclk_q;
   assign MOSI = mosi_q;
   assign BUSY = busy_q;
   assign DOUT = dout_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Scoreboard bench for spi_byte_engine: instance 0 uses CLK_DIV=1/GAP=1, instance 1 CLK_DIV=3/GAP=0.
module tb_spi_byte_engine;

   typedef struct {
      int dout;
      int mosi;
      int busy;
      int high;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       sndrec [2];
   logic [7:0] din    [2];
   logic       miso   [2];
   logic       sclk   [2];
   logic       mosi   [2];
   logic       busy   [2];
   logic [7:0] dout   [2];
   logic [7:0] slv_sr [2];

   exp_t       exp_q[$];
   logic [7:0] slv_q[$];
   int         n_checks;
   int         n_fail;

   spi_byte_engine u_dut0 (
      .CLK(clk), .RST(rst_n), .sndRec(sndrec[0]), .DIN(din[0]), .MISO(miso[0]),
      .SCLK(sclk[0]), .MOSI(mosi[0]), .BUSY(busy[0]), .DOUT(dout[0])
   );

   spi_byte_engine #(.DATA_W(8), .CLK_DIV(3), .GAP_CYCLES(0)) u_dut1 (
      .CLK(clk), .RST(rst_n), .sndRec(sndrec[1]), .DIN(din[1]), .MISO(miso[1]),
      .SCLK(sclk[1]), .MOSI(mosi[1]), .BUSY(busy[1]), .DOUT(dout[1])
   );

   assign miso[0] = slv_sr[0][7];
   assign miso[1] = slv_sr[1][7];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Wait on negedges until busy[d] equals lvl; an expired budget is a failed check.
   task automatic wait_busy(input int d, input logic lvl, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy[d] == lvl) return;
      end
      check("busy_timeout", 0, 1);
   endtask

   // Negedge controller model: raise sndRec while idle, drop it once BUSY is seen.
   task automatic issue(input int d, input logic [7:0] tx, input logic [7:0] rx,
                        input int div, input int gap, input bit expect_frame);
      exp_t e;
      wait_busy(d, 1'b0, 200);
      sndrec[d] = 1'b1;
      din[d]    = tx;
      slv_q.push_back(rx);
      if (expect_frame) begin
         e.dout = int'(rx);
         e.mosi = int'(tx);
         e.busy = 16 * div + gap;
         e.high = 8 * div;
         exp_q.push_back(e);
      end
      wait_busy(d, 1'b1, 10);
      sndrec[d] = 1'b0;
   endtask

   // Monitor and slave model: assemble each frame, compare against the scoreboard at BUSY fall.
   initial begin
      logic       busy_prev [2];
      logic       sclk_prev [2];
      logic       mosi_prev [2];
      bit         in_xfer   [2];
      int         busy_cnt  [2];
      int         high_cnt  [2];
      int         rise_cnt  [2];
      int         viol      [2];
      logic [7:0] mosi_word [2];
      exp_t       e;
      for (int d = 0; d < 2; d++) begin
         busy_prev[d] = 1'b0; sclk_prev[d] = 1'b0; mosi_prev[d] = 1'b0; in_xfer[d] = 1'b0;
         slv_sr[d] = 8'h00;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
               in_xfer[d] = 1'b0; busy_prev[d] = 1'b0; sclk_prev[d] = 1'b0;
            end else begin
               if (busy[d] && !busy_prev[d]) begin
                  in_xfer[d] = 1'b1; busy_cnt[d] = 0; high_cnt[d] = 0; rise_cnt[d] = 0;
                  viol[d] = 0; mosi_word[d] = 8'h00;
                  slv_sr[d] = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
               end
               if (busy[d]) busy_cnt[d]++;
               if (sclk[d]) high_cnt[d]++;
               if (sclk[d] && sclk_prev[d] && (mosi[d] != mosi_prev[d])) viol[d]++;
               if (sclk[d] && !sclk_prev[d]) begin
                  mosi_word[d] = {mosi_word[d][6:0], mosi[d]};
                  rise_cnt[d]++;
                  slv_sr[d] = {slv_sr[d][6:0], 1'b0};
               end
               if (!busy[d] && busy_prev[d] && in_xfer[d]) begin
                  in_xfer[d] = 1'b0;
                  if (exp_q.size() == 0) begin
                     check("unexpected_frame", 1, 0);
                  end else begin
                     e = exp_q.pop_front();
                     check("dout", int'(dout[d]), e.dout);
                     check("mosi_word", int'(mosi_word[d]), e.mosi);
                     check("busy_cycles", busy_cnt[d], e.busy);
                     check("sclk_high_cycles", high_cnt[d], e.high);
                     check("sclk_rises", rise_cnt[d], 8);
                     check("mosi_moved_while_sclk_high", viol[d], 0);
                  end
               end
               busy_prev[d] = busy[d];
               sclk_prev[d] = sclk[d];
               mosi_prev[d] = mosi[d];
            end
         end
      end
   end

   initial begin
      logic [7:0] slave_tab [5];
      slave_tab[0] = 8'h11; slave_tab[1] = 8'h22; slave_tab[2] = 8'h4B;
      slave_tab[3] = 8'hF0; slave_tab[4] = 8'h0F;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      for (int d = 0; d < 2; d++) begin
         sndrec[d] = 1'b0;
         din[d]    = 8'h00;
      end

      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("reset_sclk", int'(sclk[d]), 0);
         check("reset_mosi", int'(mosi[d]), 0);
         check("reset_busy", int'(busy[d]), 0);
         check("reset_dout", int'(dout[d]), 0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single byte A5 out, 3C in.
      issue(0, 8'hA5, 8'h3C, 1, 1, 1'b1);
      wait_busy(0, 1'b0, 100);
      repeat (2) @(negedge clk);

      // Reset at bit 4 of an 8'h55 frame: sixth... fifth SCLK rise is at accept+9.
      issue(0, 8'h55, 8'hAA, 1, 1, 1'b0);
      repeat (9) @(negedge clk);
      check("pre_reset_sclk", int'(sclk[0]), 1);
      check("pre_reset_busy", int'(busy[0]), 1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_sclk", int'(sclk[0]), 0);
      check("abort_mosi", int'(mosi[0]), 0);
      check("abort_busy", int'(busy[0]), 0);
      check("abort_dout", int'(dout[0]), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      issue(0, 8'h96, 8'h69, 1, 1, 1'b1);
      wait_busy(0, 1'b0, 100);

      // Five back-to-back transfers 80..84.
      for (int i = 0; i < 5; i++) begin
         issue(0, 8'h80 + 8'(i), slave_tab[i], 1, 1, 1'b1);
      end
      wait_busy(0, 1'b0, 100);
      repeat (2) @(negedge clk);

      // sndRec pulse and DIN churn mid-frame must not disturb the C3 frame.
      issue(0, 8'hC3, 8'h5A, 1, 1, 1'b1);
      repeat (3) @(negedge clk);
      din[0]    = 8'h00;
      sndrec[0] = 1'b1;
      @(negedge clk);
      sndrec[0] = 1'b0;
      din[0]    = 8'hFF;
      repeat (2) @(negedge clk);
      din[0]    = 8'h12;
      wait_busy(0, 1'b0, 100);
      repeat (4) @(negedge clk);
      check("no_restart_busy", int'(busy[0]), 0);

      // Slow clock, no gap, all ones.
      issue(1, 8'hFF, 8'hC6, 3, 0, 1'b1);
      wait_busy(1, 1'b0, 200);
      repeat (3) @(negedge clk);

      check("scoreboard_empty", exp_q.size(), 0);
      check("slave_queue_empty", slv_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
